// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard/forwarding logic.
package mips_pkg;

  // Register-address width of the shadow pipeline slots.
  localparam int SLOT_ADDR_W = 5;

  // Forwarding-mux select encodings (code 3 is never driven).
  localparam logic [1:0] FWD_REGFILE = 2'd0;  // value read in ID, carried in ID/EX
  localparam logic [1:0] FWD_WB      = 2'd1;  // MEM/WB write-back data
  localparam logic [1:0] FWD_EXMEM   = 2'd2;  // EX/MEM ALU result

  // $zero is hard-wired; writes to it must never be forwarded.
  localparam logic [SLOT_ADDR_W-1:0] REG_ZERO = '0;

  // Destination-register information tracked per pipeline stage.
  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] dest;
    logic                   reg_write;
    logic                   mem_read;
  } slot_t;

endpackage

// File: rtl/fwd_compare.sv
// Priority comparison of one source register against the EX and MEM shadow
// slots. Produces the forwarding select and a flag for a matching load in EX.
module fwd_compare
  import mips_pkg::*;
(
  input  logic [SLOT_ADDR_W-1:0] src_i,
  input  logic                   uses_i,
  input  slot_t                  ex_slot_i,
  input  slot_t                  mem_slot_i,
  output logic [1:0]             sel_o,
  output logic                   load_hit_o
);

  logic ex_hit;
  logic mem_hit;

  // The MEM slot's load bit plays no part in forwarding.
  logic unused_mem_read;
  assign unused_mem_read = mem_slot_i.mem_read;

  // A slot matches when it will really write the register this instruction reads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ex_hit     = 1'b0;
    mem_hit    = 1'b0;
    sel_o      = FWD_REGFILE;
    load_hit_o = 1'b0;

    if (uses_i && (src_i != REG_ZERO)) begin
      ex_hit  = ex_slot_i.valid  && ex_slot_i.reg_write  && (ex_slot_i.dest  == src_i);
      mem_hit = mem_slot_i.valid && mem_slot_i.reg_write && (mem_slot_i.dest == src_i);
    end

    // The younger producer (EX) holds the newest value, so it wins.
    if (ex_hit) begin
      sel_o = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_o = FWD_WB;
    end

    load_hit_o = ex_hit && ex_slot_i.mem_read;
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Hazard controller beside ID/EX: forwarding selects for the ALU operand
// muxes, load-use stall, branch flush, and stall/flush performance counters.
module forward_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // Shadow pipeline of destination info for EX, MEM and WB.
  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;

  logic [1:0]       a_sel_q, b_sel_q;
  logic [1:0]       a_sel_d, b_sel_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;

  logic [1:0] rs_sel, rt_sel;
  logic       rs_load_hit, rt_load_hit;

  // The register file bypasses write-back data itself, so the WB slot is
  // tracked for completeness but never consulted.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  fwd_compare u_cmp_rs (
    .src_i      (id_rs),
    .uses_i     (id_uses_rs),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (rs_sel),
    .load_hit_o (rs_load_hit)
  );

  fwd_compare u_cmp_rt (
    .src_i      (id_rt),
    .uses_i     (id_uses_rt),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (rt_sel),
    .load_hit_o (rt_load_hit)
  );

  // Stall/flush decision and next-state for the ID->EX transfer.
  always_comb begin
    // Flush beats stall; both are held low while reset is asserted.
    flush = !rst && ex_branch_taken;
    stall = !rst && !ex_branch_taken && id_valid && (rs_load_hit || rt_load_hit);

    ex_d    = '0;
    a_sel_d = FWD_REGFILE;
    b_sel_d = FWD_REGFILE;
    if (id_valid && !stall && !flush) begin
      ex_d.valid     = 1'b1;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
    end
    if (!stall && !flush) begin
      a_sel_d = rs_sel;
      b_sel_d = rt_sel;
    end
  end

  // Advance the shadow pipeline, register the selects, and count events.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      a_sel_q       <= FWD_REGFILE;
      b_sel_q       <= FWD_REGFILE;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      if (stall) stall_count_q <= stall_count_q + CNT_W'(1);
      if (flush) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign fwd_a_sel   = a_sel_q;
  assign fwd_b_sel   = b_sel_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed test of forward_hazard_ctrl with hand-computed expected values.
module tb_forward_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read;
  logic        ex_branch_taken;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall, flush;
  logic [31:0] stall_count, flush_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  forward_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dest         (id_dest),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .stall           (stall),
    .flush           (flush),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one ID-stage instruction.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic br);
    id_valid        = v;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rs      = urs;
    id_uses_rt      = urt;
    id_dest         = dest;
    id_reg_write    = rw;
    id_mem_read     = mr;
    ex_branch_taken = br;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    tick();
    tick();

    // Reset state
    check("rst_a_sel", fwd_a_sel, 0);
    check("rst_b_sel", fwd_b_sel, 0);
    check("rst_stall", stall, 0);
    check("rst_stall_cnt", stall_count, 0);
    check("rst_flush_cnt", flush_count, 0);
    ex_branch_taken = 1'b1;
    #1 check("rst_flush_masked", flush, 0);
    ex_branch_taken = 1'b0;
    rst = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    @(negedge clk) check("t1_add_stall", stall, 0);
    tick();
    check("t1_add_a", fwd_a_sel, 0);
    check("t1_add_b", fwd_b_sel, 0);
    drive(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0);
    tick();
    check("t1_sub_a", fwd_a_sel, 2);
    check("t1_sub_b", fwd_b_sel, 0);

    // add $3 ; and $11,$12,$13 ; or $6,$7,$3  -> MEM forward on B
    bubble(); tick(); bubble(); tick();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);    tick();
    drive(1, 5'd12, 5'd13, 1, 1, 5'd11, 1, 0, 0); tick();
    drive(1, 5'd7, 5'd3, 1, 1, 5'd6, 1, 0, 0);    tick();
    check("t2_or_a", fwd_a_sel, 0);
    check("t2_or_b_mem", fwd_b_sel, 1);
    // add $3 ; addi $3,$3,1 ; or $6,$7,$3 -> EX beats MEM
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);    tick();
    drive(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0);    tick();
    check("t2_addi_a", fwd_a_sel, 2);
    drive(1, 5'd7, 5'd3, 1, 1, 5'd6, 1, 0, 0);    tick();
    check("t2_or_b_prio", fwd_b_sel, 2);
    check("t2_or_a2", fwd_a_sel, 0);

    // lw $8,0($9) ; add $10,$8,$8 -> one-cycle stall, then select 1
    bubble(); tick(); bubble(); tick();
    drive(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0);    tick();
    drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0);
    @(negedge clk) check("t3_stall_on", stall, 1);
    tick();
    check("t3_bubble_a", fwd_a_sel, 0);
    check("t3_bubble_b", fwd_b_sel, 0);
    check("t3_stall_cnt", stall_count, 1);
    @(negedge clk) check("t3_stall_off", stall, 0);
    tick();
    check("t3_add_a", fwd_a_sel, 1);
    check("t3_add_b", fwd_b_sel, 1);
    check("t3_stall_cnt2", stall_count, 1);

    // Writes to $0 never forward or stall
    bubble(); tick(); bubble(); tick();
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);    tick();
    drive(1, 5'd0, 5'd0, 1, 1, 5'd10, 1, 0, 0);
    @(negedge clk) check("t4_zero_stall", stall, 0);
    tick();
    check("t4_zero_a", fwd_a_sel, 0);
    check("t4_zero_b", fwd_b_sel, 0);
    drive(1, 5'd9, 5'd0, 1, 0, 5'd0, 1, 1, 0);    tick();
    drive(1, 5'd0, 5'd0, 1, 1, 5'd10, 1, 0, 0);
    @(negedge clk) check("t4_lw0_stall", stall, 0);
    tick();
    check("t4_lw0_a", fwd_a_sel, 0);

    // Load-use coinciding with taken branch -> flush wins
    bubble(); tick(); bubble(); tick();
    drive(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0);    tick();
    drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 1);
    @(negedge clk);
    check("t5_flush", flush, 1);
    check("t5_stall", stall, 0);
    tick();
    check("t5_a", fwd_a_sel, 0);
    check("t5_b", fwd_b_sel, 0);
    check("t5_flush_cnt", flush_count, 1);
    check("t5_stall_cnt", stall_count, 1);
    // Reader of $10: would see select 2 if the flushed add had entered EX
    drive(1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0);
    @(negedge clk) check("t5_flush_off", flush, 0);
    tick();
    check("t5_ex_bubbled", fwd_a_sel, 0);

    // Reset pulsed during a stall cycle
    bubble(); tick(); bubble(); tick();
    drive(1, 5'd9, 5'd0, 1, 0, 5'd8, 1, 1, 0);    tick();
    drive(1, 5'd8, 5'd8, 1, 1, 5'd10, 1, 0, 0);
    @(negedge clk) check("t6_stall_on", stall, 1);
    rst = 1'b1;
    #1 check("t6_rst_stall_mask", stall, 0);
    tick();
    rst = 1'b0;
    check("t6_a", fwd_a_sel, 0);
    check("t6_b", fwd_b_sel, 0);
    check("t6_stall_cnt", stall_count, 0);
    check("t6_flush_cnt", flush_count, 0);
    @(negedge clk) check("t6_stall_cleared", stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
